// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-bit positions, ALU control codes
// and the opcode-to-control lookup used by the decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_ALUOP1   = 7;
  localparam int CTRL_ALUOP0   = 8;

  localparam logic [1:0] ALU_CTRL_ADD       = 2'b00;
  localparam logic [1:0] ALU_CTRL_SUB       = 2'b01;
  localparam logic [1:0] ALU_CTRL_FUNCT     = 2'b10;
  localparam logic [1:0] ALU_CTRL_LOGIC_IMM = 2'b11;

  typedef logic [0:8] ctrlT;

  typedef struct packed {
    ctrlT       ctrl;
    logic [1:0] aluCtrl;
    logic       illegal;
    logic       usesRt;
  } opDecodeT;

  // Control literals read left to right as regDst .. aluOp0.
  function automatic opDecodeT decodeOpcode(input logic [5:0] opcode);
    opDecodeT d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl    = 9'b1_0_0_1_0_0_0_1_0;
        d.aluCtrl = ALU_CTRL_FUNCT;
        d.usesRt  = 1'b1;
      end
      OP_LW: begin
        d.ctrl    = 9'b0_1_1_1_1_0_0_0_0;
        d.aluCtrl = ALU_CTRL_ADD;
      end
      OP_SW: begin
        d.ctrl    = 9'b0_1_0_0_0_1_0_0_0;
        d.aluCtrl = ALU_CTRL_ADD;
        d.usesRt  = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl    = 9'b0_0_0_0_0_0_1_0_1;
        d.aluCtrl = ALU_CTRL_SUB;
        d.usesRt  = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl    = 9'b0_1_0_1_0_0_0_0_0;
        d.aluCtrl = ALU_CTRL_ADD;
      end
      OP_ANDI, OP_ORI: begin
        d.ctrl    = 9'b0_1_0_1_0_0_0_1_1;
        d.aluCtrl = ALU_CTRL_LOGIC_IMM;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_pipelined_reg_file_bypass.sv
// Two-read, one-write register file with r0 tied to zero and optional
// same-cycle forwarding of the write-back data onto the read ports.
module reg_file_bypass #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [AW-1:0]     rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrEn
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              bypassA, bypassB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign bypassA = (WB_BYPASS != 0) && wrEn && (rdAddrA == wrAddr);
  assign bypassB = (WB_BYPASS != 0) && wrEn && (rdAddrB == wrAddr);

  // The r0 check comes first so a write-back aimed at r0 is never forwarded.
  always_comb begin
    rdDataA = regs[rdAddrA];
    if (rdAddrA == '0)  rdDataA = '0;
    else if (bypassA)   rdDataA = wrData;
  end

  always_comb begin
    rdDataB = regs[rdAddrB];
    if (rdAddrB == '0)  rdDataB = '0;
    else if (bypassB)   rdDataB = wrData;
  end

endmodule

// File: rtl/decode_pipelined.sv
// Decode stage owning the ID/EX register: decodes IF/ID, reads the register
// file and stalls on load-use hazards against its own ID/EX contents.
module decode_pipelined
  import decode_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int IMM_SIGNED = 1,
  parameter int WB_BYPASS  = 1,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              flush,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_we,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_valid,
  output logic [0:8]        idex_ctrl,
  output logic [1:0]        idex_alu_ctrl,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [REG_AW-1:0] idex_rd,
  output logic              idex_illegal
);

  opDecodeT          dec;
  logic [REG_AW-1:0] rs, rt, rdField, rdSel;
  logic [DATA_W-1:0] immExt, rsData, rtData;
  logic              signExt, hazard, bubble;

  assign dec     = decodeOpcode(instr[31:26]);
  assign rs      = instr[21 +: REG_AW];
  assign rt      = instr[16 +: REG_AW];
  assign rdField = instr[11 +: REG_AW];
  assign rdSel   = dec.ctrl[CTRL_REGDST] ? rdField : rt;

  // Logical immediates are always zero-extended regardless of IMM_SIGNED.
  assign signExt = (IMM_SIGNED != 0) && (instr[31:26] != OP_ANDI) && (instr[31:26] != OP_ORI);
  assign immExt  = signExt ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
                           : {{(DATA_W-16){1'b0}}, instr[15:0]};

  assign hazard = idex_valid & idex_ctrl[CTRL_MEMREAD] & (idex_rt != '0) & instr_valid &
                  ((idex_rt == rs) | (dec.usesRt & (idex_rt == rt)));

  // A redirect discards the dependent instruction, so it overrides the stall.
  assign bubble     = flush | hazard;
  assign pc_write   = flush | ~hazard;
  assign ifid_write = flush | ~hazard;

  reg_file_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .WB_BYPASS(WB_BYPASS)
  ) uRegFile (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdAddrA(rs),
    .rdDataA(rsData),
    .rdAddrB(rt),
    .rdDataB(rtData),
    .wrAddr (wb_rd),
    .wrData (wb_data),
    .wrEn   (wb_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid    <= 1'b0;
      idex_ctrl     <= '0;
      idex_alu_ctrl <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
      idex_illegal  <= 1'b0;
    end else if (bubble) begin
      idex_valid    <= 1'b0;
      idex_ctrl     <= '0;
      idex_alu_ctrl <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
      idex_illegal  <= 1'b0;
    end else begin
      idex_valid    <= instr_valid;
      idex_ctrl     <= dec.ctrl;
      idex_alu_ctrl <= dec.aluCtrl;
      idex_rs_data  <= rsData;
      idex_rt_data  <= rtData;
      idex_imm      <= immExt;
      idex_rs       <= rs;
      idex_rt       <= rt;
      idex_rd       <= rdSel;
      idex_illegal  <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_decode_pipelined.sv
// Bench for decode_pipelined: a forwarding/sign-extending instance and a
// non-forwarding/zero-extending instance, checked against a behavioural model.
module tb_decode_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, flush, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        pcWrite1, ifidWrite1, idexValid1, illegal1;
  logic [0:8]  idexCtrl1;
  logic [1:0]  idexAlu1;
  logic [31:0] rsData1, rtData1, imm1;
  logic [4:0]  rs1, rt1, rd1;

  logic        pcWrite0, ifidWrite0, idexValid0, illegal0;
  logic [0:8]  idexCtrl0;
  logic [1:0]  idexAlu0;
  logic [31:0] rsData0, rtData0, imm0;
  logic [4:0]  rs0, rt0, rd0;

  always #5 clk = ~clk;

  decode_pipelined #(.DATA_W(32), .NUM_REGS(32), .IMM_SIGNED(1), .WB_BYPASS(1)) dutByp (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .pc_write(pcWrite1), .ifid_write(ifidWrite1), .idex_valid(idexValid1),
    .idex_ctrl(idexCtrl1), .idex_alu_ctrl(idexAlu1), .idex_rs_data(rsData1),
    .idex_rt_data(rtData1), .idex_imm(imm1), .idex_rs(rs1), .idex_rt(rt1),
    .idex_rd(rd1), .idex_illegal(illegal1));

  decode_pipelined #(.DATA_W(32), .NUM_REGS(32), .IMM_SIGNED(0), .WB_BYPASS(0)) dutNoByp (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .pc_write(pcWrite0), .ifid_write(ifidWrite0), .idex_valid(idexValid0),
    .idex_ctrl(idexCtrl0), .idex_alu_ctrl(idexAlu0), .idex_rs_data(rsData0),
    .idex_rt_data(rtData0), .idex_imm(imm0), .idex_rs(rs0), .idex_rt(rt0),
    .idex_rd(rd0), .idex_illegal(illegal0));

  // ctrl is written left to right as regDst .. aluOp0, so ctrl[8] is regDst, ctrl[4] memRead.
  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [1:0]  alu;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        illegal;
  } idexT;

  idexT got1, got0, expIdex1, expIdex0;
  assign got1 = {idexValid1, idexCtrl1, idexAlu1, rsData1, rtData1, imm1, rs1, rt1, rd1, illegal1};
  assign got0 = {idexValid0, idexCtrl0, idexAlu0, rsData0, rtData0, imm0, rs0, rt0, rd0, illegal0};

  logic [31:0] modelRegs [32];
  int nAssert = 0;
  int nFail   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [8:0]  ctrl;
    logic [1:0]  alu;
    logic        ill;
    logic [31:0] immS;
    logic [31:0] immZ;
  } vecT;
  vecT vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkIdex(input string name, input idexT act, input idexT exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void opInfo(input logic [5:0] op, output logic [8:0] ctrl,
                                 output logic [1:0] alu, output logic ill,
                                 output logic usesRt, output logic logicImm);
    ctrl = '0; alu = '0; ill = 1'b0; usesRt = 1'b0; logicImm = 1'b0;
    case (op)
      6'h00: begin ctrl = 9'b100100010; alu = 2'b10; usesRt = 1'b1; end
      6'h23: begin ctrl = 9'b011110000; alu = 2'b00; end
      6'h2B: begin ctrl = 9'b010001000; alu = 2'b00; usesRt = 1'b1; end
      6'h04: begin ctrl = 9'b000000101; alu = 2'b01; usesRt = 1'b1; end
      6'h08: begin ctrl = 9'b010100000; alu = 2'b00; end
      6'h0C, 6'h0D: begin ctrl = 9'b010100011; alu = 2'b11; logicImm = 1'b1; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] readModel(input logic [4:0] idx, input bit bypass);
    if (idx == 0) return 32'h0;
    if (bypass && wb_we && (wb_rd == idx)) return wb_data;
    return modelRegs[idx];
  endfunction

  function automatic idexT modelDecode(input logic [31:0] ins, input logic v,
                                       input bit bypass, input bit immSigned);
    idexT e;
    logic usesRt, logicImm;
    e = '0;
    opInfo(ins[31:26], e.ctrl, e.alu, e.illegal, usesRt, logicImm);
    e.valid  = v;
    e.rs     = ins[25:21];
    e.rt     = ins[20:16];
    e.rd     = e.ctrl[8] ? ins[15:11] : ins[20:16];
    e.rsData = readModel(e.rs, bypass);
    e.rtData = readModel(e.rt, bypass);
    e.imm    = (immSigned && !logicImm) ? {{16{ins[15]}}, ins[15:0]} : {16'h0, ins[15:0]};
    return e;
  endfunction

  function automatic bit modelHazard();
    logic [8:0] c; logic [1:0] a; logic ill, usesRt, li;
    opInfo(instr[31:26], c, a, ill, usesRt, li);
    return expIdex1.valid && expIdex1.ctrl[4] && (expIdex1.rt != 0) && instr_valid &&
           ((expIdex1.rt == instr[25:21]) || (usesRt && (expIdex1.rt == instr[20:16])));
  endfunction

  // One clock: check the stall outputs, advance the model, check both ID/EX registers.
  task automatic tick(output bit haz, output logic pw);
    idexT n1, n0;
    bit expPw;
    #2;
    haz   = modelHazard();
    expPw = flush || !haz;
    pw    = pcWrite1;
    chk("pc_write", pcWrite1, expPw);
    chk("ifid_write", ifidWrite1, expPw);
    chk("pc_write_nobyp", pcWrite0, expPw);
    if (flush || haz) begin
      n1 = '0; n0 = '0;
    end else begin
      n1 = modelDecode(instr, instr_valid, 1'b1, 1'b1);
      n0 = modelDecode(instr, instr_valid, 1'b0, 1'b0);
    end
    @(posedge clk);
    if (wb_we && (wb_rd != 0)) modelRegs[wb_rd] = wb_data;
    expIdex1 = n1;
    expIdex0 = n0;
    #1;
    chkIdex("idex_byp", got1, expIdex1);
    chkIdex("idex_nobyp", got0, expIdex0);
  endtask

  task automatic doReset();
    rst_n = 1'b0; wb_we = 1'b0; instr_valid = 1'b0; flush = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    expIdex1 = '0; expIdex0 = '0;
    chkIdex("reset_idex_byp", got1, '0);
    chkIdex("reset_idex_nobyp", got0, '0);
    chk("reset_pc_write", pcWrite1, 1);
    chk("reset_ifid_write", ifidWrite1, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] val);
    bit h; logic p;
    wb_we = 1'b1; wb_rd = idx; wb_data = val; instr_valid = 1'b0; flush = 1'b0;
    tick(h, p);
    wb_we = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F};
    return {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD_3_1_2 = 32'h00221820;
  localparam logic [31:0] LW_4_0_1  = 32'h8C240000;
  localparam logic [31:0] ADD_5_4_2 = 32'h00822820;

  initial begin
    bit   haz;
    logic pw;
    bit   held;

    vecs[0] = '{32'h00221820, 9'b100100010, 2'b10, 1'b0, 32'h00001820, 32'h00001820};
    vecs[1] = '{32'h8C240000, 9'b011110000, 2'b00, 1'b0, 32'h00000000, 32'h00000000};
    vecs[2] = '{32'hAC45FFFC, 9'b010001000, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h0000FFFC};
    vecs[3] = '{32'h10220008, 9'b000000101, 2'b01, 1'b0, 32'h00000008, 32'h00000008};
    vecs[4] = '{32'h2006FFFF, 9'b010100000, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0000FFFF};
    vecs[5] = '{32'h30278000, 9'b010100011, 2'b11, 1'b0, 32'h00008000, 32'h00008000};
    vecs[6] = '{32'h3428FFFF, 9'b010100011, 2'b11, 1'b0, 32'h0000FFFF, 32'h0000FFFF};
    vecs[7] = '{32'hFC000000, 9'b000000000, 2'b00, 1'b1, 32'h00000000, 32'h00000000};
    vecs[8] = '{32'h08000000, 9'b000000000, 2'b00, 1'b1, 32'h00000000, 32'h00000000};

    instr = '0; wb_rd = '0; wb_data = '0;
    doReset();

    for (int i = 0; i < 9; i++) begin
      instr = vecs[i].ins; instr_valid = 1'b1;
      tick(haz, pw);
      chk("vec_ctrl", idexCtrl1, vecs[i].ctrl);
      chk("vec_alu", idexAlu1, vecs[i].alu);
      chk("vec_illegal", illegal1, vecs[i].ill);
      chk("vec_imm_signed", imm1, vecs[i].immS);
      chk("vec_imm_zero", imm0, vecs[i].immZ);
      instr_valid = 1'b0;
      tick(haz, pw);
    end

    writeReg(5'd1, 32'd7);
    writeReg(5'd2, 32'd9);
    instr = ADD_3_1_2; instr_valid = 1'b1;
    tick(haz, pw);
    chk("rtype_ctrl", idexCtrl1, 9'b100100010);
    chk("rtype_rd", rd1, 3);
    chk("rtype_rs_data", rsData1, 7);
    chk("rtype_rt_data", rtData1, 9);

    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    tick(haz, pw);
    chk("bypass_rt_data", rtData1, 32'hDEADBEEF);
    chk("nobypass_old_data", rtData0, 9);
    wb_we = 1'b0;
    tick(haz, pw);
    chk("nobypass_after_write", rtData0, 32'hDEADBEEF);
    instr = 32'h00001820; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    tick(haz, pw);
    chk("r0_no_forward", rsData1, 0);
    wb_we = 1'b0;
    tick(haz, pw);
    chk("r0_write_dropped", rsData1, 0);
    chk("r0_write_dropped_nobyp", rtData0, 0);

    instr = LW_4_0_1;
    tick(haz, pw);
    instr = ADD_5_4_2;
    tick(haz, pw);
    chk("loaduse_hazard", haz, 1);
    chk("loaduse_pc_write", pw, 0);
    chk("loaduse_bubble", idexValid1, 0);
    tick(haz, pw);
    chk("loaduse_release_pc_write", pw, 1);
    chk("loaduse_decoded_valid", idexValid1, 1);
    chk("loaduse_decoded_rd", rd1, 5);

    instr = LW_4_0_1;
    tick(haz, pw);
    instr = ADD_5_4_2; flush = 1'b1;
    tick(haz, pw);
    chk("flush_pc_write", pw, 1);
    chk("flush_bubble", idexValid1, 0);
    flush = 1'b0;
    tick(haz, pw);
    chk("flush_no_stall_after", pw, 1);
    chk("flush_next_valid", idexValid1, 1);

    instr = LW_4_0_1;
    tick(haz, pw);
    instr = ADD_5_4_2; instr_valid = 1'b0;
    tick(haz, pw);
    chk("invalid_no_stall", pw, 1);
    instr_valid = 1'b1;

    writeReg(5'd5, 32'h55);
    instr = 32'h00A01800; instr_valid = 1'b1;
    tick(haz, pw);
    chk("pre_reset_r5", rsData1, 32'h55);
    doReset();
    instr = 32'h00A01800; instr_valid = 1'b1;
    tick(haz, pw);
    chk("post_reset_r5", rsData1, 0);

    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        instr       = randInstr();
        instr_valid = ($urandom_range(0, 9) < 8);
      end
      flush   = ($urandom_range(0, 9) == 0);
      wb_we   = $urandom_range(0, 1);
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      tick(haz, pw);
      held = !pw;
    end
    flush = 1'b0; wb_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/decode_pipelined.md
# decode_pipelined

Parametrised decode stage that owns its ID/EX pipeline register. It decodes the instruction held in IF/ID, reads a bypassing register file, and detects load-use hazards against its own ID/EX contents. On a hazard it stalls fetch and IF/ID and inserts a bubble; on a branch redirect it flushes. It sits between the IF/ID register and the execute stage.

## Interface
- DATA_W, 32, register and datapath width
- NUM_REGS, 32, architectural registers; index width REG_AW = $clog2(NUM_REGS)
- IMM_SIGNED, 1, 1: sign-extend imm16 except andi/ori; 0: always zero-extend
- WB_BYPASS, 1, 1: same-cycle write-back data is forwarded to the reads
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- instr  input  32  IF/ID instruction
- instr_valid  input  1  IF/ID holds a real instruction
- flush  input  1  branch redirect from EX; squash the instruction in decode
- wb_rd  input  REG_AW  write-back register
- wb_data  input  DATA_W  write-back data
- wb_we  input  1  write-back enable
- pc_write  output  1  PC may advance (combinational)
- ifid_write  output  1  IF/ID may load (combinational)
- idex_valid  output  1  ID/EX holds a real instruction
- idex_ctrl  output  [0:8]  regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp1, aluOp0
- idex_alu_ctrl  output  2  00 add, 01 sub, 10 funct, 11 logic-imm
- idex_rs_data, idex_rt_data  output  DATA_W  operands
- idex_imm  output  DATA_W  extended imm16
- idex_rs, idex_rt, idex_rd  output  REG_AW  register indices; idex_rd is already muxed by regDst
- idex_illegal  output  1  unknown opcode

## Operation
- Opcodes:
  - 0x00 R-type: ctrl 1_0_0_1_0_0_0_1_0, alu 10
  - 0x23 lw: ctrl 0_1_1_1_1_0_0_0_0, alu 00
  - 0x2B sw: ctrl 0_1_0_0_0_1_0_0_0, alu 00
  - 0x04 beq: ctrl 0_0_0_0_0_0_1_0_1, alu 01
  - 0x08 addi: ctrl 0_1_0_1_0_0_0_0_0, alu 00
  - 0x0C andi, 0x0D ori: ctrl 0_1_0_1_0_0_0_1_1, alu 11
  - Other opcodes: ctrl all zero, illegal = 1.
- Index fields: rs = instr[25:21], rt = instr[20:16], rd field = instr[15:11], each truncated to REG_AW bits.
- uses_rt = R-type, sw, beq.
- Register file:
  - Register 0 reads as zero; writes to register 0 are dropped.
  - Writes occur at the clk edge when wb_we = 1.
  - With WB_BYPASS = 1, a read whose index equals a non-zero wb_rd while wb_we = 1 returns wb_data.
- hazard = idex_valid & idex_ctrl[4] & (idex_rt != 0) & instr_valid & ((idex_rt == rs) | (uses_rt & idex_rt == rt)).
- Priority per cycle:
  1. flush: load a bubble; pc_write = ifid_write = 1.
  2. hazard: load a bubble; pc_write = ifid_write = 0.
  3. Otherwise: load the decoded instruction with idex_valid = instr_valid; pc_write = ifid_write = 1.
- Bubble: idex_valid = 0 and all idex_* fields = 0. The register file still commits the write-back.

## Timing
- Reset (async assert): all ID/EX outputs 0, every register-file entry 0. pc_write and ifid_write follow the combinational equations, so they read 1 because idex_valid = 0.
- Decode latency: one cycle, IF/ID to ID/EX.
- A load-use stall lasts exactly one cycle. The bubble clears idex_valid, so hazard deasserts on the next cycle and the held instruction decodes.
- flush during a hazard: the flush wins, and there is no stall.
- A write-back in the same cycle as a read of the same register sees the new data when WB_BYPASS = 1, and the old data when WB_BYPASS = 0.
- instr_valid = 0 is never a hazard and never stalls.

## Structure
- Package decode_pkg holds:
  - opcode localparams
  - control-bit index constants (CTRL_REGDST … CTRL_ALUOP0)
  - ALU_CTRL_* encodings
  - a function returning {ctrl, alu_ctrl, illegal, uses_rt} for an opcode
- One sub-module, reg_file_bypass, with parameters DATA_W, NUM_REGS, WB_BYPASS. It has two read ports and one write port, and r0 is hardwired to zero.

## Test plan
- Reset: hold rst_n = 0 mid-run, then release. Required: idex_valid = 0, idex_ctrl = 0, pc_write = 1, and a read of r5 returns 0.
- R-type: `add $3,$1,$2` (0x00221820) with r1 = 7, r2 = 9. Required next cycle: idex_ctrl = 1_0_0_1_0_0_0_1_0, idex_rd = 3, operands 7 and 9.
- Load-use: `lw $4,0($1)` followed by `add $5,$4,$2`. Required: one cycle with pc_write = 0, ifid_write = 0 and a bubble in ID/EX, then the add decodes.
- Bypass: wb_we = 1, wb_rd = 2, wb_data = 0xDEADBEEF, while `add $3,$1,$2` is in decode. Required: idex_rt_data = 0xDEADBEEF. Write-back to r0 is dropped.
- Flush during hazard: the load-use pair with flush = 1 in the stall cycle. Required: bubble, pc_write = 1, and no stall cycle follows.
- Illegal and immediate handling:
  - Opcode 0x3F: required idex_illegal = 1, idex_ctrl = 0.
  - `addi` with imm16 = 0xFFFF: required idex_imm = 0xFFFFFFFF.
  - `ori` with imm16 = 0xFFFF: required idex_imm = 0x0000FFFF.
